// File: rtl/array_rw_initiator_pkg.sv
// Shared definitions for the array_rw_initiator block.
//   state_e     : controller FSM states (zero-fill, then normal operation)
//   RESP_DEPTH  : entries in the read-response FIFO (also the read credit limit)
//   RESP_CNT_W  : width of the FIFO occupancy count
//   resp_ptr_inc: wrap-around increment for FIFO pointers
package array_rw_initiator_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RESP_DEPTH = 3;
  localparam int RESP_CNT_W = 2;

  // Pointers walk 0,1,2,0,... because the depth is not a power of two.
  function automatic logic [RESP_CNT_W-1:0] resp_ptr_inc(input logic [RESP_CNT_W-1:0] p);
    return (p == RESP_CNT_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// 3-entry synchronous FIFO holding read data until the consumer takes it.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   push, push_data       : write one entry (ignored when full)
//   pop                   : discard the head entry (ignored when empty)
//   head_data             : current head entry, meaningful when count != 0
//   count                 : occupancy, 0..RESP_DEPTH
// Push and pop in the same cycle leave the occupancy unchanged.
module resp_fifo
  import array_rw_initiator_pkg::*;
#(
  parameter int DATA_W = 392
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     head_data,
  output logic [RESP_CNT_W-1:0] count
);

  logic [DATA_W-1:0]     store [RESP_DEPTH];
  logic [RESP_CNT_W-1:0] wr_ptr;
  logic [RESP_CNT_W-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_push   = push && (count != RESP_CNT_W'(RESP_DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = store[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= resp_ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= resp_ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Data storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/array_rw_initiator.sv
// Request-side controller for a single-port, 1-cycle-latency SRAM macro.
// After reset it zero-fills every entry (INIT), then forwards read/write
// requests to the macro (RUN) and returns read data in request order.
// Ports:
//   clock, reset                 : sole clock, asynchronous active-high reset
//   req_*                        : request channel (valid/ready)
//   resp_valid/resp_ready/resp_data : response channel (valid/ready)
//   init_done                    : zero-fill finished
//   mem_*                        : macro RW port (mem_rdata valid the cycle
//                                  after a read-enable cycle only)
//   fsm_state                    : current FSM state, for observation
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high; valid does not depend on ready, and req_ready never depends
// on resp_ready.
module array_rw_initiator
  import array_rw_initiator_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 392,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_W-1:0]     init_cnt;
  logic                  rd_inflight;  // a read was accepted last cycle
  logic                  rd_accept;
  logic                  rd_credit;
  logic [RESP_CNT_W-1:0] fifo_count;

  // Reads may only be accepted while the FIFO can absorb every read already
  // issued, so the FIFO never overflows even with resp_ready held low.
  assign rd_credit = ({1'b0, fifo_count} + {{RESP_CNT_W{1'b0}}, rd_inflight})
                     < (RESP_CNT_W+1)'(RESP_DEPTH);
  assign rd_accept = req_valid && req_ready && !req_write;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= rd_accept;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = req_addr;
    mem_wmask = req_wmask;
    mem_wdata = req_wdata;
    case (state)
      ST_INIT: begin
        // Gated by reset so the macro stays idle while reset is held.
        mem_en    = !reset;
        mem_wmode = !reset;
        mem_addr  = init_cnt;
        mem_wmask = '1;
        mem_wdata = '0;
        if (init_cnt == LAST_ADDR) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = req_write ? 1'b1 : rd_credit;
        mem_en    = req_valid && req_ready;
        mem_wmode = req_write;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // mem_rdata is only captured in the cycle after an accepted read.
  resp_fifo #(.DATA_W(DATA_W)) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_inflight),
    .push_data (mem_rdata),
    .pop       (resp_ready),
    .head_data (resp_data),
    .count     (fifo_count)
  );

  assign resp_valid = (fifo_count != '0);
  assign init_done  = (state == ST_RUN);
  assign fsm_state  = state;

endmodule

// File: tb/tb_array_rw_initiator.sv
// Directed bench for array_rw_initiator with an SRAM macro model and a
// response scoreboard.
module tb_array_rw_initiator;
  import array_rw_initiator_pkg::*;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 392;
  localparam int MASK_W = 4;
  localparam int SEG_W  = DATA_W / MASK_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_wmode;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              fsm_state;

  array_rw_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  // ---------------- check bookkeeping ----------------
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < (DATA_W + 31) / 32; i++) w = {w[DATA_W-33:0], $urandom()};
    return w;
  endfunction

  // ---------------- SRAM macro model ----------------
  // rdata is garbage on every cycle that does not follow a read enable.
  logic [DATA_W-1:0] sram [DEPTH];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= rand_word();
      mem_rdata <= rand_word();
    end else begin
      if (mem_en && mem_wmode)
        for (int s = 0; s < MASK_W; s++)
          if (mem_wmask[s]) sram[mem_addr][s*SEG_W +: SEG_W] <= mem_wdata[s*SEG_W +: SEG_W];
      if (mem_en && !mem_wmode) mem_rdata <= sram[mem_addr];
      else                      mem_rdata <= rand_word();
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      chk("reset_resp_valid", resp_valid, 1'b0);
    end else begin
      if (exp_q.size() == 0) chk("spurious_resp_valid", resp_valid, 1'b0);
      if (req_valid && req_ready && !req_write)
        chk("read_credit", exp_q.size() < 3, 1'b1);
      if (resp_valid && resp_ready && exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk("resp_data", resp_data, mon_exp);
      end
      if (req_valid && req_ready && !req_write) exp_q.push_back(ref_mem[req_addr]);
      if (req_valid && req_ready && req_write)
        for (int s = 0; s < MASK_W; s++)
          if (req_wmask[s]) ref_mem[req_addr][s*SEG_W +: SEG_W] = req_wdata[s*SEG_W +: SEG_W];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Drive one request until accepted (bounded), then drop valid.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [MASK_W-1:0] m, input logic [DATA_W-1:0] d,
                       input string tag);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      step();
      @(negedge clock);
      waited++;
    end
    chk({tag, "_accept"}, req_ready, 1'b1);
    step();
    idle();
  endtask

  task automatic wait_drain(input string tag);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      step();
      waited++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Called right after reset deassertion: DEPTH zero-fill cycles, then RUN.
  task automatic check_init(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clock);
      chk({tag, "_port"}, {mem_en, mem_wmode, mem_wmask, mem_addr},
          {1'b1, 1'b1, 4'hf, 2'(a)});
      chk({tag, "_wdata"}, mem_wdata, '0);
      chk({tag, "_req_ready"}, {req_ready, init_done}, 2'b00);
      step();
    end
    @(negedge clock);
    chk({tag, "_done"}, {init_done, req_ready, fsm_state}, {1'b1, 1'b1, ST_RUN});
    step();
  endtask

  // ---------------- directed sequence ----------------
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] masked_exp;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  int                rd_addrs [5];
  int                idx;

  initial begin
    reset      = 1'b1;
    resp_ready = 1'b1;
    req_addr   = '0;
    req_wmask  = '0;
    req_wdata  = '0;
    idle();
    pattern    = {4'h1, {96{4'ha}}, 4'h5};
    ones       = '1;
    masked_exp = {{SEG_W{1'b0}}, {SEG_W{1'b1}}, {SEG_W{1'b0}}, {SEG_W{1'b1}}};
    data_a     = rand_word();
    data_b     = rand_word();
    rd_addrs   = '{0, 1, 2, 3, 0};

    // Reset values.
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {req_ready, resp_valid, init_done, mem_en, mem_wmode}, 5'b0);

    // Zero-fill after reset release.
    @(posedge clock);
    #1 reset = 1'b0;
    check_init("init");

    // Back-to-back reads of every address: one per cycle, latency 2.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 2'(i);
      end else idle();
      @(negedge clock);
      if (i < 4) chk("burst_req_ready", req_ready, 1'b1);
      chk("burst_resp_valid", resp_valid, i >= 2);
      step();
    end

    // Full write then read-after-write of the same entry.
    issue(1'b1, 2'd2, 4'hf, pattern, "wr_pat");
    issue(1'b0, 2'd2, 4'h0, '0, "rd_pat");
    @(negedge clock);
    chk("pat_lat1_valid", resp_valid, 1'b0);
    step();
    @(negedge clock);
    chk("pat_lat2_valid", resp_valid, 1'b1);
    chk("pat_data", resp_data, pattern);
    step();

    // Masked write of all-ones onto a zeroed entry.
    issue(1'b1, 2'd3, 4'b0101, ones, "wr_mask");
    issue(1'b0, 2'd3, 4'h0, '0, "rd_mask");
    step();
    @(negedge clock);
    chk("mask_data", resp_data, masked_exp);
    step();
    wait_drain("mask");

    // Backpressure: only three reads accepted while resp_ready is low.
    resp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 2'(rd_addrs[idx]);
      @(negedge clock);
      if (req_ready) idx++;
      step();
    end
    chk("bp_accepted", idx, 3);
    req_addr = 2'(rd_addrs[idx]);
    #1 chk("bp_read_blocked", req_ready, 1'b0);
    req_write = 1'b1;
    req_addr  = 2'd1;
    req_wmask = 4'hf;
    req_wdata = data_b;
    #1 chk("bp_write_ready", req_ready, 1'b1);
    step();
    req_write  = 1'b0;
    req_addr   = 2'(rd_addrs[idx]);
    resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_blocked_until_pop", req_ready, 1'b0);
    step();
    @(negedge clock);
    chk("bp_reopen", req_ready, 1'b1);
    step();
    idle();
    issue(1'b0, 2'(rd_addrs[4]), 4'h0, '0, "bp_rd5");
    wait_drain("bp");

    // Write A then read of the same address on the very next cycle.
    issue(1'b1, 2'd1, 4'hf, data_a, "wr_a");
    issue(1'b0, 2'd1, 4'h0, '0, "rd_a");
    step();
    @(negedge clock);
    chk("b2b_data", resp_data, data_a);
    step();
    wait_drain("b2b");

    // Reset in the capture cycle of a read: no response, array re-zeroed.
    issue(1'b0, 2'd2, 4'h0, '0, "rd_rst");
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_resp_valid", resp_valid, 1'b0);
    step();
    reset = 1'b0;
    check_init("reinit");
    issue(1'b0, 2'd2, 4'h0, '0, "rd_after_rst");
    step();
    @(negedge clock);
    chk("rezero_data", resp_data, '0);
    step();
    for (int a = 0; a < DEPTH; a++) issue(1'b0, 2'(a), 4'h0, '0, "rd_zero");
    wait_drain("final");

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/array_rw_initiator.md
# array_rw_initiator

Request-side controller that drives a single-port, 1-cycle-latency SRAM macro (one shared RW port: addr, en, wmode, per-segment wmask, wdata, rdata). It zero-fills the array after reset, accepts read and write requests on a valid/ready channel, and issues them to the macro. It captures read data on the only cycle the macro guarantees it valid and returns that data on a backpressured response channel. It sits between cache/predictor logic and an `array_*_ext` instance.

## Interface
- ADDR_W, 2, macro address width; DEPTH = 2^ADDR_W entries
- DATA_W, 392, macro data width
- MASK_W, 4, write-mask segments; SEG_W = DATA_W/MASK_W (98); DATA_W % MASK_W == 0 required
- clock  in  1  sole clock; also drives the macro clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  entry index
- req_wmask  in  MASK_W  segment enables; ignored for reads
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_data
- resp_data  out  DATA_W  read data, in request order
- init_done  out  1  zero-fill complete
- mem_addr  out  ADDR_W  to macro addr
- mem_en  out  1  to macro en
- mem_wmode  out  1  to macro wmode
- mem_wmask  out  MASK_W  to macro wmask
- mem_wdata  out  DATA_W  to macro wdata
- mem_rdata  in  DATA_W  from macro rdata; valid only the cycle after a read-enable cycle

## Operation
- FSM states: INIT, RUN. Reset enters INIT with init counter 0.
- INIT: every cycle drive mem_en=1, mem_wmode=1, mem_wmask all ones, mem_wdata=0, mem_addr=counter. Increment the counter. After writing entry DEPTH-1, go to RUN and set init_done=1. req_ready=0 throughout INIT.
- RUN, macro port is combinational from the request: mem_en = req_valid && req_ready; mem_wmode = req_write; mem_addr, mem_wmask, mem_wdata pass through.
- Writes: req_ready=1 unconditionally in RUN. Writes produce no response.
- Reads: accepted only when count + inflight < 3.
  - count = occupancy of the 3-entry response FIFO.
  - inflight = 1 if a read was accepted the previous cycle.
  - req_ready has no combinational dependence on resp_ready.
- Capture: a registered flag marks the cycle after an accepted read. In that cycle mem_rdata is pushed into the FIFO. mem_rdata is never sampled on any other cycle, since it may be garbage.
- FIFO: 3 entries with wrap-around pointers. resp_valid = count != 0; resp_data = head entry. A push and a pop in the same cycle leaves count unchanged. Overflow is impossible by the credit rule; the verifier asserts it.
- A read immediately following a write to the same address returns the new data, because the macro orders the operations.
- Reset at any time: FIFO, inflight flag and count are cleared, and the FSM restarts INIT. In-flight and buffered read data are discarded, with no response.

## Timing
- Reset values: req_ready=0, resp_valid=0, init_done=0, mem_en=0, mem_wmode=0. resp_data is don't-care while resp_valid=0.
- INIT occupies exactly DEPTH cycles after reset deassertion; the first request can be accepted in cycle DEPTH.
- Read accepted in cycle t: macro enabled in t, mem_rdata captured at end of t+1, resp_valid high in t+2. Load-to-use latency is 2.
- Sustained throughput is one read per cycle while resp_ready=1. Writes are always one per cycle.
- With resp_ready=0, at most 3 reads are accepted, then req_ready drops for reads. It rises the cycle after the first pop.

## Structure
- Shared package holds the FSM state enum (INIT, RUN) and the constant RESP_DEPTH=3.
- One sub-module: `resp_fifo`, a 3-entry, DATA_W-wide synchronous FIFO with count output and async active-high reset.

## Test plan
- Reset release: mem_en=1/wmode=1/wdata=0 for addresses 0,1,2,3 in 4 consecutive cycles, then init_done=1 and req_ready=1 in cycle 4. Reads of all addresses return 0.
- Write addr 2 with 0x1…5 pattern and mask 4'b1111, then read addr 2: resp_data equals the pattern 2 cycles after read acceptance.
- Masked write 4'b0101 over all-ones data onto a zeroed entry, then read: segments 0 and 2 are ones, segments 1 and 3 are zero.
- Hold resp_ready=0 and issue 5 reads to addrs 0..3,0: exactly 3 accepted, then req_ready=0 for reads while writes are still accepted. Release resp_ready: responses arrive in order.
- Back-to-back write addr1=A then read addr1 on the next cycle: response is A. Continuous reads with resp_ready=1 give one response per cycle.
- Assert reset in the cycle after a read is accepted: no resp_valid appears, and INIT re-runs and re-zeroes the array.
